// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter
//   Shares one SDRAM controller port between a read-only display fetch path
//   (port 0, fixed priority) and a host read/write path (port 1). A bounded
//   streak counter lets port 1 in after STARVE_LIMIT consecutive port-0 grants
//   made while port 1 was waiting. Accesses that see no controller ack within
//   ACK_TIMEOUT BUSY cycles are aborted, and the sticky o_timeout flag is set.
//
// Ports
//   iclk_50, ireset             clock, synchronous active-high reset
//   i_p0_req/addr               port 0 read request (level, held until ack)
//   o_p0_data/ack               port 0 read data (held) and one-cycle ack
//   i_p1_req/we/addr/wdata      port 1 request, direction, address, write data
//   o_p1_data/ack               port 1 read data and one-cycle ack
//   o_mem_req/we/addr/wdata     registered request to the SDRAM controller
//   i_mem_data/ack              controller read data and completion strobe
//   o_busy                      high while an access is in BUSY or RESP
//   o_timeout                   sticky abort flag, cleared only by reset
module sdram_read_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic         iclk_50,
  input  logic         ireset,
  input  logic         i_p0_req,
  input  logic [21:0]  i_p0_addr,
  output logic [127:0] o_p0_data,
  output logic         o_p0_ack,
  input  logic         i_p1_req,
  input  logic         i_p1_we,
  input  logic [21:0]  i_p1_addr,
  input  logic [127:0] i_p1_wdata,
  output logic [127:0] o_p1_data,
  output logic         o_p1_ack,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [21:0]  o_mem_addr,
  output logic [127:0] o_mem_wdata,
  input  logic [127:0] i_mem_data,
  input  logic         i_mem_ack,
  output logic         o_busy,
  output logic         o_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_BUSY = 3'b010,
    ST_RESP = 3'b100
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [9:0] TMO_MAX    = 10'(ACK_TIMEOUT);

  state_t         state_q, state_d;
  logic [3:0]     streak_q, streak_d;
  logic [9:0]     tmo_q, tmo_d;
  logic           gnt_p1_q, gnt_p1_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [21:0]    mem_addr_q, mem_addr_d;
  logic [127:0]   mem_wdata_q, mem_wdata_d;
  logic [127:0]   p0_data_q, p0_data_d;
  logic [127:0]   p1_data_q, p1_data_d;
  logic           p0_ack_q, p0_ack_d;
  logic           p1_ack_q, p1_ack_d;
  logic           timeout_q, timeout_d;
  logic           pick_p1;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    gnt_p1_d    = gnt_p1_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_data_d   = p0_data_q;
    p1_data_d   = p1_data_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    timeout_d   = timeout_q;
    // Port 1 wins when alone, or when port 0 has used up its streak.
    pick_p1     = i_p1_req && (!i_p0_req || (streak_q == STREAK_MAX));

    case (state_q)
      ST_IDLE: begin
        if (i_p0_req || i_p1_req) begin
          mem_req_d = 1'b1;
          tmo_d     = '0;
          state_d   = ST_BUSY;
          if (pick_p1) begin
            gnt_p1_d    = 1'b1;
            mem_we_d    = i_p1_we;
            mem_addr_d  = i_p1_addr;
            mem_wdata_d = i_p1_wdata;
            streak_d    = '0;
          end else begin
            gnt_p1_d    = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_p0_addr;
            mem_wdata_d = '0;
            // Only port-0 grants that made port 1 wait count towards the streak.
            if (!i_p1_req) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + 4'd1;
            end
          end
        end
      end

      ST_BUSY: begin
        if (i_mem_ack) begin
          if (gnt_p1_q) begin
            p1_data_d = i_mem_data;
            p1_ack_d  = 1'b1;
          end else begin
            p0_data_d = i_mem_data;
            p0_ack_d  = 1'b1;
          end
          mem_req_d = 1'b0;
          tmo_d     = '0;
          state_d   = ST_RESP;
        end else if ((tmo_q + 10'd1) == TMO_MAX) begin
          // Abort silently; the requester still holds its request and is
          // simply re-arbitrated from IDLE.
          mem_req_d = 1'b0;
          tmo_d     = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iclk_50) begin
    if (ireset) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      gnt_p1_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_data_q   <= '0;
      p1_data_q   <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      gnt_p1_q    <= gnt_p1_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_data_q   <= p0_data_d;
      p1_data_q   <= p1_data_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_p0_data   = p0_data_q;
  assign o_p0_ack    = p0_ack_q;
  assign o_p1_data   = p1_data_q;
  assign o_p1_ack    = p1_ack_q;
  assign o_timeout   = timeout_q;
  assign o_busy      = (state_q == ST_BUSY) || (state_q == ST_RESP);

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter with STARVE_LIMIT=4, ACK_TIMEOUT=8.
module tb_sdram_read_arbiter;

  logic         iclk_50;
  logic         ireset;
  logic         i_p0_req;
  logic [21:0]  i_p0_addr;
  logic [127:0] o_p0_data;
  logic         o_p0_ack;
  logic         i_p1_req;
  logic         i_p1_we;
  logic [21:0]  i_p1_addr;
  logic [127:0] i_p1_wdata;
  logic [127:0] o_p1_data;
  logic         o_p1_ack;
  logic         o_mem_req;
  logic         o_mem_we;
  logic [21:0]  o_mem_addr;
  logic [127:0] o_mem_wdata;
  logic [127:0] i_mem_data;
  logic         i_mem_ack;
  logic         o_busy;
  logic         o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] DATA_P0  = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] PAT_A    = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [127:0] PAT_X    = 128'h0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF;
  localparam logic [127:0] DATA_ST  = 128'hCAFE_F00D_0000_0001_0000_0002_0000_0003;
  localparam logic [127:0] DATA_TO  = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [127:0] DATA_LATE = 128'hBAD0_BAD1_BAD2_BAD3_BAD4_BAD5_BAD6_BAD7;

  sdram_read_arbiter #(
    .STARVE_LIMIT(4),
    .ACK_TIMEOUT (8)
  ) dut (
    .iclk_50    (iclk_50),
    .ireset     (ireset),
    .i_p0_req   (i_p0_req),
    .i_p0_addr  (i_p0_addr),
    .o_p0_data  (o_p0_data),
    .o_p0_ack   (o_p0_ack),
    .i_p1_req   (i_p1_req),
    .i_p1_we    (i_p1_we),
    .i_p1_addr  (i_p1_addr),
    .i_p1_wdata (i_p1_wdata),
    .o_p1_data  (o_p1_data),
    .o_p1_ack   (o_p1_ack),
    .o_mem_req  (o_mem_req),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_data (i_mem_data),
    .i_mem_ack  (i_mem_ack),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout)
  );

  initial iclk_50 = 1'b0;
  always #5 iclk_50 = ~iclk_50;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk_50);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int order[$];
    int exp_order[10];
    int both_cnt;
    int cnt;
    int ack_seen;

    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    ireset     = 1'b1;
    i_p0_req   = 1'b0;
    i_p0_addr  = '0;
    i_p1_req   = 1'b0;
    i_p1_we    = 1'b0;
    i_p1_addr  = '0;
    i_p1_wdata = '0;
    i_mem_data = '0;
    i_mem_ack  = 1'b0;
    tick();
    tick();
    ireset = 1'b0;

    // Reset state
    check("rst_mem_req", 128'(o_mem_req), 128'(0));
    check("rst_busy", 128'(o_busy), 128'(0));
    check("rst_timeout", 128'(o_timeout), 128'(0));
    check("rst_p0_data", o_p0_data, 128'(0));

    // Single p0 read, controller acks 5 cycles after o_mem_req rises
    i_p0_req  = 1'b1;
    i_p0_addr = 22'h00ABC;
    tick();
    check("p0_mem_req", 128'(o_mem_req), 128'(1));
    check("p0_mem_addr", 128'(o_mem_addr), 128'(22'h00ABC));
    check("p0_mem_we", 128'(o_mem_we), 128'(0));
    check("p0_busy", 128'(o_busy), 128'(1));
    ack_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_p0_ack || o_p1_ack || !o_mem_req) ack_seen++;
    end
    check("p0_wait_quiet", 128'(ack_seen), 128'(0));
    i_mem_ack  = 1'b1;
    i_mem_data = DATA_P0;
    tick();
    i_mem_ack  = 1'b0;
    i_mem_data = '0;
    check("p0_ack", 128'(o_p0_ack), 128'(1));
    check("p0_data", o_p0_data, DATA_P0);
    check("p0_p1_ack", 128'(o_p1_ack), 128'(0));
    check("p0_req_drop", 128'(o_mem_req), 128'(0));
    tick();
    // Back-to-back handshake: request dropped in the cycle after the ack
    i_p0_req = 1'b0;
    check("b2b_ack_once", 128'(o_p0_ack), 128'(0));
    tick();
    check("b2b_no_regrant", 128'(o_mem_req), 128'(0));
    check("b2b_busy", 128'(o_busy), 128'(0));
    check("b2b_data_held", o_p0_data, DATA_P0);

    // p1 write; port inputs changed mid-access must not matter
    i_p1_req   = 1'b1;
    i_p1_we    = 1'b1;
    i_p1_addr  = 22'h12345;
    i_p1_wdata = PAT_A;
    tick();
    i_p1_addr  = 22'h3FFFF;
    i_p1_wdata = PAT_X;
    i_p1_we    = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1 || o_mem_wdata !== PAT_A ||
          o_mem_addr !== 22'h12345) cnt++;
      tick();
    end
    check("p1w_stable", 128'(cnt), 128'(0));
    i_mem_ack  = 1'b1;
    i_mem_data = PAT_X;
    tick();
    i_mem_ack = 1'b0;
    i_p1_req  = 1'b0;
    check("p1w_ack", 128'(o_p1_ack), 128'(1));
    check("p1w_p0_ack", 128'(o_p0_ack), 128'(0));
    tick();
    check("p1w_ack_once", 128'(o_p1_ack), 128'(0));
    tick();

    // Starvation rule: both ports request continuously
    i_p0_req   = 1'b1;
    i_p0_addr  = 22'h00100;
    i_p1_req   = 1'b1;
    i_p1_we    = 1'b0;
    i_p1_addr  = 22'h00200;
    i_mem_data = DATA_ST;
    both_cnt   = 0;
    for (int c = 0; c < 80 && order.size() < 10; c++) begin
      i_mem_ack = o_mem_req;
      tick();
      if (o_p0_ack && o_p1_ack) both_cnt++;
      if (o_p0_ack) order.push_back(0);
      else if (o_p1_ack) order.push_back(1);
    end
    i_p0_req  = 1'b0;
    i_p1_req  = 1'b0;
    i_mem_ack = 1'b0;
    check("starve_cnt", 128'(order.size()), 128'(10));
    for (int i = 0; i < order.size() && i < 10; i++)
      check($sformatf("starve_order%0d", i), 128'(order[i]), 128'(exp_order[i]));
    check("starve_both_ack", 128'(both_cnt), 128'(0));
    check("starve_p1_data", o_p1_data, DATA_ST);
    tick();
    tick();
    check("starve_idle", 128'(o_busy), 128'(0));

    // Timeout: p0 read never acked
    i_mem_data = '0;
    i_p0_req   = 1'b1;
    i_p0_addr  = 22'h3ABCD;
    tick();
    cnt      = 0;
    ack_seen = 0;
    while (o_mem_req && cnt < 20) begin
      cnt++;
      tick();
      if (o_p0_ack) ack_seen++;
    end
    check("to_req_cycles", 128'(cnt), 128'(8));
    check("to_no_ack", 128'(ack_seen), 128'(0));
    check("to_flag", 128'(o_timeout), 128'(1));
    check("to_idle", 128'(o_busy), 128'(0));
    tick();
    check("to_regrant", 128'(o_mem_req), 128'(1));
    check("to_regrant_addr", 128'(o_mem_addr), 128'(22'h3ABCD));
    i_mem_ack  = 1'b1;
    i_mem_data = DATA_TO;
    tick();
    i_mem_ack = 1'b0;
    i_p0_req  = 1'b0;
    check("to_retry_ack", 128'(o_p0_ack), 128'(1));
    check("to_retry_data", o_p0_data, DATA_TO);
    tick();
    check("to_sticky", 128'(o_timeout), 128'(1));

    // Reset in the middle of a p1 read; the controller acks late
    i_p1_req  = 1'b1;
    i_p1_we   = 1'b0;
    i_p1_addr = 22'h00777;
    tick();
    tick();
    check("rstm_busy_before", 128'(o_busy), 128'(1));
    ireset = 1'b1;
    tick();
    ireset     = 1'b0;
    i_p1_req   = 1'b0;
    i_mem_ack  = 1'b1;
    i_mem_data = DATA_LATE;
    check("rstm_mem_req", 128'(o_mem_req), 128'(0));
    check("rstm_mem_addr", 128'(o_mem_addr), 128'(0));
    check("rstm_p0_data", o_p0_data, 128'(0));
    check("rstm_p1_data", o_p1_data, 128'(0));
    check("rstm_timeout", 128'(o_timeout), 128'(0));
    check("rstm_busy", 128'(o_busy), 128'(0));
    tick();
    i_mem_ack = 1'b0;
    ack_seen  = 0;
    for (int i = 0; i < 3; i++) begin
      if (o_p1_ack || o_p0_ack || o_busy) ack_seen++;
      tick();
    end
    check("rstm_late_ack_ignored", 128'(ack_seen), 128'(0));
    check("rstm_p1_data_clear", o_p1_data, 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_read_arbiter.md
Name: sdram_read_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters:
  - Port 0: display fetch path, read-only, 128-bit line reads at 22-bit line addresses.
  - Port 1: host/frame-writer path, read or write.
- Port 0 has fixed priority so scan-out never stalls. A bounded-streak rule keeps port 1 from starving.
- Sits between the VGA SDRAM adapter / host logic and the SDRAM controller. Single iclk_50 domain.

Parameters:
- STARVE_LIMIT, 4: consecutive port-0 grants allowed while port 1 waits (legal 1..15).
- ACK_TIMEOUT, 255: cycles in BUSY without i_mem_ack before the access is aborted (legal 1..1023).

Ports:
- iclk_50  in  1  system clock; all logic on rising edge.
- ireset  in  1  synchronous, active-high reset.
- i_p0_req  in  1  port 0 read request; level, held until o_p0_ack.
- i_p0_addr  in  22  port 0 line address.
- o_p0_data  out  128  port 0 read data; valid when o_p0_ack=1, held afterwards.
- o_p0_ack  out  1  one-cycle completion pulse for port 0.
- i_p1_req  in  1  port 1 request; level, held until o_p1_ack.
- i_p1_we  in  1  port 1 direction: 1 = write, 0 = read.
- i_p1_addr  in  22  port 1 line address.
- i_p1_wdata  in  128  port 1 write data.
- o_p1_data  out  128  port 1 read data; valid when o_p1_ack=1.
- o_p1_ack  out  1  one-cycle completion pulse for port 1; fires for reads and writes.
- o_mem_req  out  1  request to SDRAM controller.
- o_mem_we  out  1  write enable to SDRAM controller.
- o_mem_addr  out  22  address to SDRAM controller.
- o_mem_wdata  out  128  write data to SDRAM controller.
- i_mem_data  in  128  read data from SDRAM controller; valid with i_mem_ack.
- i_mem_ack  in  1  controller completion strobe.
- o_busy  out  1  high in BUSY and RESP states.
- o_timeout  out  1  sticky; set on any aborted access; cleared only by ireset.

Behaviour:
- Reset (ireset=1 at a clock edge):
  - State goes to IDLE; streak counter and timeout counter clear to 0.
  - All outputs go to 0, including data registers and o_timeout.
  - Takes effect immediately even mid-access; no ack is issued for the aborted access.
- State machine. One-hot states IDLE, BUSY, RESP.
- IDLE:
  - Sample i_p0_req and i_p1_req at the clock edge and pick a winner:
    - p0 only: grant p0.
    - p1 only: grant p1.
    - both, streak < STARVE_LIMIT: grant p0.
    - both, streak == STARVE_LIMIT: grant p1.
  - On grant, latch the winner's address, we (forced 0 for p0) and wdata into the o_mem_* registers. Set o_mem_req=1 and go to BUSY.
  - Latency: o_mem_req is high in the cycle after a request is sampled.
  - With no request, stay in IDLE with o_mem_req=0.
- Streak counter (4 bits, saturating at STARVE_LIMIT):
  - +1 on a p0 grant while i_p1_req=1.
  - Clears to 0 on any p1 grant, or on a p0 grant while i_p1_req=0.
- BUSY:
  - o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata are held stable.
  - Timeout counter increments each cycle.
  - i_mem_ack=1:
    - Capture i_mem_data into the granted port's data register; on writes the capture is harmless.
    - Drop o_mem_req and clear the timeout counter.
    - Go to RESP.
  - Timeout counter reaches ACK_TIMEOUT with no ack:
    - Drop o_mem_req, set o_timeout, go to IDLE, issue no ack.
    - The requester still holds its request and is re-arbitrated; the streak counter is not updated.
- RESP:
  - The granted port's o_pX_ack is 1 for exactly this one cycle.
  - Always go to IDLE next.
  - Request-to-ack minimum is 3 cycles (grant, ack-capture, RESP).
- Handshake:
  - A requester must deassert its request no later than the cycle after its ack.
  - IDLE samples at its closing edge, so a request dropped during the IDLE cycle is not re-granted.
- Port inputs are ignored outside IDLE; changing address or data mid-access has no effect.
- i_mem_ack outside BUSY is ignored.
- o_p0_ack and o_p1_ack are never high in the same cycle.
- o_busy = BUSY or RESP.

Test Plan:
- Single p0 read:
  - Stimulus: i_p0_req=1, addr=22'h00ABC; controller acks 5 cycles after o_mem_req rises, with data 128'hDEAD...BEEF.
  - Required: o_mem_addr=0x00ABC, o_mem_we=0; o_p0_ack pulses once with o_p0_data=DEAD...BEEF; o_p1_ack stays 0.
- p1 write:
  - Stimulus: i_p1_we=1, addr=0x12345, wdata=pattern A.
  - Required: o_mem_we=1 and o_mem_wdata=A are stable through BUSY; o_p1_ack pulses once, one cycle after i_mem_ack.
- Starvation rule:
  - Stimulus: p0 and p1 both continuously requesting, STARVE_LIMIT=4, controller acks each access after 1 cycle.
  - Required: grant order is p0,p0,p0,p0,p1,p0,p0,p0,p0,p1…
- Timeout:
  - Stimulus: ACK_TIMEOUT=8; controller never acks a p0 read.
  - Required: o_mem_req is high for exactly 8 BUSY cycles then drops; o_timeout=1 and stays set; no o_p0_ack; p0 is re-granted on the next IDLE.
- Reset mid-BUSY:
  - Stimulus: assert ireset for 1 cycle during a p1 read; controller acks in the following cycle.
  - Required: all outputs 0 the cycle after reset; the late i_mem_ack is ignored; no o_p1_ack.
- Back-to-back handshake:
  - Stimulus: requester drops i_p0_req the cycle after o_p0_ack, and p1 is idle.
  - Required: no second p0 grant; state returns to IDLE with o_busy=0.
